// File: rtl/pixel_mem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous pixel RAM
// between two masters. It serialises their accesses and routes read data
// back to whichever master issued the read.
module pixel_mem_arbiter #(
  parameter int A_WIDTH = 17,
  parameter int D_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  // requester 0
  input  logic               R0_Req,
  input  logic               R0_RW,
  input  logic [A_WIDTH-1:0] R0_Addr,
  input  logic [D_WIDTH-1:0] R0_WData,
  output logic               R0_Gnt,
  output logic               R0_RValid,
  output logic [D_WIDTH-1:0] R0_RData,
  // requester 1
  input  logic               R1_Req,
  input  logic               R1_RW,
  input  logic [A_WIDTH-1:0] R1_Addr,
  input  logic [D_WIDTH-1:0] R1_WData,
  output logic               R1_Gnt,
  output logic               R1_RValid,
  output logic [D_WIDTH-1:0] R1_RData,
  // RAM side
  output logic               M_En,
  output logic               M_RW,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic [D_WIDTH-1:0] M_WData,
  input  logic [D_WIDTH-1:0] M_RData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  // r_last names the requester that won most recently (1 = R1), so the other one wins a tie
  logic                 r_last;
  logic                 w_nextLast;
  logic                 w_elig0;
  logic                 w_elig1;

  logic                 r_mEn;
  logic                 r_mRw;
  logic [A_WIDTH-1:0]   r_mAddr;
  logic [D_WIDTH-1:0]   r_mWData;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 w_nextRw;
  logic [A_WIDTH-1:0]   w_nextAddr;
  logic [D_WIDTH-1:0]   w_nextWData;

  logic                 r_tagValid;
  logic                 r_tagOwner;

  // A requester that holds the RAM this cycle is not eligible again, so its stale Req is ignored
  assign w_elig0 = R0_Req & ~r_gnt0;
  assign w_elig1 = R1_Req & ~r_gnt1;

  // Next-state arbitration plus the request fields captured for the coming RAM cycle
  always_comb begin
    w_nextState = IDLE;
    w_nextLast  = r_last;
    w_nextRw    = 1'b0;
    w_nextAddr  = '0;
    w_nextWData = '0;
    if (w_elig0 && w_elig1) begin
      w_nextState = r_last ? G0 : G1;
    end else if (w_elig0) begin
      w_nextState = G0;
    end else if (w_elig1) begin
      w_nextState = G1;
    end
    case (w_nextState)
      G0: begin
        w_nextLast  = 1'b0;
        w_nextRw    = R0_RW;
        w_nextAddr  = R0_Addr;
        w_nextWData = R0_WData;
      end
      G1: begin
        w_nextLast  = 1'b1;
        w_nextRw    = R1_RW;
        w_nextAddr  = R1_Addr;
        w_nextWData = R1_WData;
      end
      default: ;
    endcase
  end

  // State register and round-robin pointer
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
    end
  end

  // Registered RAM command and grant pulses, decoded from the next state
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mEn    <= 1'b0;
      r_mRw    <= 1'b0;
      r_mAddr  <= '0;
      r_mWData <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
    end else begin
      r_mEn    <= (w_nextState != IDLE);
      r_mRw    <= w_nextRw;
      r_mAddr  <= w_nextAddr;
      r_mWData <= w_nextWData;
      r_gnt0   <= (w_nextState == G0);
      r_gnt1   <= (w_nextState == G1);
    end
  end

  // Read tag: remembers that the RAM cycle just issued was a read and who owns its data
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_tagValid <= 1'b0;
      r_tagOwner <= 1'b0;
    end else begin
      r_tagValid <= r_mEn & ~r_mRw;
      r_tagOwner <= r_gnt1;
    end
  end

  assign M_En      = r_mEn;
  assign M_RW      = r_mRw;
  assign M_Addr    = r_mAddr;
  assign M_WData   = r_mWData;
  assign R0_Gnt    = r_gnt0;
  assign R1_Gnt    = r_gnt1;
  assign R0_RValid = r_tagValid & ~r_tagOwner;
  assign R1_RValid = r_tagValid & r_tagOwner;
  assign R0_RData  = M_RData;
  assign R1_RData  = M_RData;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter with hand-computed expectations.
module tb_pixel_mem_arbiter;

  logic        Clk;
  logic        Rst;
  logic        R0_Req, R0_RW, R0_Gnt, R0_RValid;
  logic [16:0] R0_Addr;
  logic [7:0]  R0_WData, R0_RData;
  logic        R1_Req, R1_RW, R1_Gnt, R1_RValid;
  logic [16:0] R1_Addr;
  logic [7:0]  R1_WData, R1_RData;
  logic        M_En, M_RW;
  logic [16:0] M_Addr;
  logic [7:0]  M_WData, M_RData;

  int checks;
  int failures;
  int grantCount;

  pixel_mem_arbiter #(.A_WIDTH(17), .D_WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .R0_Req(R0_Req), .R0_RW(R0_RW), .R0_Addr(R0_Addr), .R0_WData(R0_WData),
    .R0_Gnt(R0_Gnt), .R0_RValid(R0_RValid), .R0_RData(R0_RData),
    .R1_Req(R1_Req), .R1_RW(R1_RW), .R1_Addr(R1_Addr), .R1_WData(R1_WData),
    .R1_Gnt(R1_Gnt), .R1_RValid(R1_RValid), .R1_RData(R1_RData),
    .M_En(M_En), .M_RW(M_RW), .M_Addr(M_Addr), .M_WData(M_WData),
    .M_RData(M_RData)
  );

  // Free-running clock, 10 time units per period
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge; grants and read-valids are never both high
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
    checkOutput("gnt_onehot", 32'(R0_Gnt & R1_Gnt), 0);
    checkOutput("rvalid_onehot", 32'(R0_RValid & R1_RValid), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Rst = 1'b1;
    R0_Req = 1'b1; R0_RW = 1'b0; R0_Addr = 17'd5; R0_WData = 8'd0;
    R1_Req = 1'b1; R1_RW = 1'b0; R1_Addr = 17'd7; R1_WData = 8'd0;
    M_RData = 8'h00;

    // 1: reset with both requesting, then R0 wins the first tie
    applyStimulus();
    checkOutput("rst_gnt0", 32'(R0_Gnt), 0);
    checkOutput("rst_gnt1", 32'(R1_Gnt), 0);
    checkOutput("rst_men", 32'(M_En), 0);
    checkOutput("rst_mrw", 32'(M_RW), 0);
    checkOutput("rst_maddr", 32'(M_Addr), 0);
    checkOutput("rst_mwdata", 32'(M_WData), 0);
    checkOutput("rst_rvalid0", 32'(R0_RValid), 0);
    checkOutput("rst_rvalid1", 32'(R1_RValid), 0);
    Rst = 1'b0;
    applyStimulus();
    checkOutput("first_gnt0", 32'(R0_Gnt), 1);
    checkOutput("first_gnt1", 32'(R1_Gnt), 0);
    checkOutput("first_maddr", 32'(M_Addr), 5);
    R0_Req = 1'b0; R1_Req = 1'b0;
    applyStimulus();
    checkOutput("first_idle_men", 32'(M_En), 0);
    checkOutput("first_rvalid0", 32'(R0_RValid), 1);

    // 2: single read at the top address
    R0_Req = 1'b1; R0_RW = 1'b0; R0_Addr = 17'd76799;
    applyStimulus();
    checkOutput("rd_gnt0", 32'(R0_Gnt), 1);
    checkOutput("rd_men", 32'(M_En), 1);
    checkOutput("rd_mrw", 32'(M_RW), 0);
    checkOutput("rd_maddr", 32'(M_Addr), 76799);
    checkOutput("rd_rvalid0_early", 32'(R0_RValid), 0);
    R0_Req = 1'b0; R0_Addr = 17'd0;
    M_RData = 8'hA5;
    applyStimulus();
    checkOutput("rd_rvalid0", 32'(R0_RValid), 1);
    checkOutput("rd_rvalid1", 32'(R1_RValid), 0);
    checkOutput("rd_rdata0", 32'(R0_RData), 32'hA5);
    checkOutput("rd_men_after", 32'(M_En), 0);
    checkOutput("rd_gnt0_after", 32'(R0_Gnt), 0);

    // 3: contention; R0 won last, so R1 goes first, then they alternate
    R0_Req = 1'b1; R0_RW = 1'b0; R0_Addr = 17'd10; R0_WData = 8'd0;
    R1_Req = 1'b1; R1_RW = 1'b1; R1_Addr = 17'd0;  R1_WData = 8'd255;
    M_RData = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      if (k % 2 == 0) begin
        checkOutput($sformatf("cont%0d_gnt1", k), 32'(R1_Gnt), 1);
        checkOutput($sformatf("cont%0d_gnt0", k), 32'(R0_Gnt), 0);
        checkOutput($sformatf("cont%0d_mrw", k), 32'(M_RW), 1);
        checkOutput($sformatf("cont%0d_mwdata", k), 32'(M_WData), 255);
        checkOutput($sformatf("cont%0d_maddr", k), 32'(M_Addr), 0);
        checkOutput($sformatf("cont%0d_rvalid0", k), 32'(R0_RValid), (k == 0) ? 0 : 1);
      end else begin
        checkOutput($sformatf("cont%0d_gnt0", k), 32'(R0_Gnt), 1);
        checkOutput($sformatf("cont%0d_gnt1", k), 32'(R1_Gnt), 0);
        checkOutput($sformatf("cont%0d_mrw", k), 32'(M_RW), 0);
        checkOutput($sformatf("cont%0d_maddr", k), 32'(M_Addr), 10);
        checkOutput($sformatf("cont%0d_rvalid_any", k), 32'(R0_RValid | R1_RValid), 0);
      end
    end
    R0_Req = 1'b0; R1_Req = 1'b0;
    applyStimulus();
    checkOutput("cont_end_rvalid0", 32'(R0_RValid), 1);
    checkOutput("cont_end_rdata0", 32'(R0_RData), 32'h3C);
    checkOutput("cont_end_men", 32'(M_En), 0);

    // 4: R1 holds Req six cycles alone -> grant every other cycle
    R1_Req = 1'b1; R1_RW = 1'b1; R1_Addr = 17'd1234; R1_WData = 8'h11;
    grantCount = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkOutput($sformatf("held%0d_gnt1", k), 32'(R1_Gnt), (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("held%0d_gnt0", k), 32'(R0_Gnt), 0);
      if (R1_Gnt) grantCount++;
    end
    checkOutput("held_grant_count", 32'(grantCount), 3);
    R1_Req = 1'b0;
    applyStimulus();
    checkOutput("held_rvalid1", 32'(R1_RValid), 0);

    // 5: reset lands in the grant cycle of a read; its data never comes back
    R0_Req = 1'b1; R0_RW = 1'b0; R0_Addr = 17'd42;
    applyStimulus();
    checkOutput("rstmid_gnt0", 32'(R0_Gnt), 1);
    Rst = 1'b1;
    R0_Req = 1'b0;
    #1;
    checkOutput("rstmid_gnt0_cleared", 32'(R0_Gnt), 0);
    checkOutput("rstmid_men_cleared", 32'(M_En), 0);
    applyStimulus();
    Rst = 1'b0;
    applyStimulus();
    checkOutput("rstmid_rvalid0", 32'(R0_RValid), 0);
    checkOutput("rstmid_gnt0_idle", 32'(R0_Gnt), 0);
    R0_Req = 1'b1;
    applyStimulus();
    checkOutput("rstmid_regrant0", 32'(R0_Gnt), 1);
    checkOutput("rstmid_regrant_maddr", 32'(M_Addr), 42);
    R0_Req = 1'b0;
    applyStimulus();
    checkOutput("rstmid_regrant_rvalid0", 32'(R0_RValid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
